issue_select: RTL and testbench
===============================

ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 Parameter NUM_ROWS, default 8, scheduler rows arbitrated; power of two, >=2.
REQ-002 Parameter MAX_LAT, default 8, largest FU latency accepted, >=2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 request_vector  input  NUM_ROWS  per-row ready-to-issue requests from wakeup logic.
REQ-006 issue_lat  input  $clog2(MAX_LAT+1)  latency of the row on issue_row, sampled at handshake.
REQ-007 issue_ready  input  1  FU accepts the offered row.
REQ-008 flush  input  1  synchronous kill of any offer or in-flight op.
REQ-009 issue_valid  output  1  row offered to FU.
REQ-010 issue_row  output  $clog2(NUM_ROWS)  offered row index.
REQ-011 free_en  output  1  one-cycle pulse releasing an issued row.
REQ-012 free_row_index  output  $clog2(NUM_ROWS)  row released by free_en.
REQ-013 clear_en  output  1  one-cycle dependency-clear pulse.
REQ-014 clear_lines  output  NUM_ROWS  one-hot column of the completing row; zero when clear_en low.
REQ-015 busy  output  1  high in BUSY state.

Function
REQ-016 FSM states IDLE, OFFER, BUSY; all outputs registered.
REQ-017 IDLE: request_vector nonzero -> select first set bit scanning upward from rr_ptr with wrap; load issue_row, set issue_valid, go OFFER next cycle; else stay IDLE.
REQ-018 OFFER: issue_valid and issue_row held stable until handshake (issue_valid & issue_ready) or drop.
REQ-019 Drop: request_vector[issue_row] low in OFFER -> issue_valid low next cycle, IDLE, no free_en; rr_ptr unchanged.
REQ-020 Handshake in cycle H (request still set): free_en=1, free_row_index=issue_row in H+1 only; issue_valid low in H+1; rr_ptr <= (issue_row+1) mod NUM_ROWS.
REQ-021 Latency L = issue_lat at H; L=0 treated as 1; L>MAX_LAT saturated to MAX_LAT.
REQ-022 L=1: clear_en pulses at H+1, FSM IDLE at H+1; L>1: FSM BUSY from H+1, down-counter loaded with L.
REQ-023 BUSY: counter decrements each cycle; clear_en pulses at H+L (baseline); FSM returns IDLE at H+L; no new offer before H+L+1.
REQ-024 clear_lines = one-hot(issued row) exactly in the clear_en cycle.
REQ-025 flush (any state): next cycle IDLE, issue_valid=0, counter=0, pending clear_en cancelled; free_en from handshake in same cycle still issued; rr_ptr kept.
REQ-026 flush has priority over handshake-initiated state change except REQ-025 free_en.
REQ-027 At most one offer outstanding; request_vector changes outside OFFER ignored.

Reset
REQ-028 rst low asynchronously forces: state IDLE, issue_valid 0, issue_row 0, free_en 0, free_row_index 0, clear_en 0, clear_lines 0, busy 0, counter 0, rr_ptr 0.
REQ-029 Reset mid-OFFER/BUSY: no free_en or clear_en pulse after release; first offer at earliest one cycle after rst rises with requests present.

Configuration
REQ-030 Macro ISSUE_SELECT_EARLY_WAKEUP_EN: defined -> clear_en/clear_lines pulse at H+max(1,L-1) (speculative back-to-back wakeup), FSM timing unchanged.
REQ-031 Macro undefined -> clear_en at H+L per REQ-022/023; no early-wakeup logic synthesized.

Verification
REQ-032 After reset, request_vector=8'b0010_0100, issue_ready=1, issue_lat=3 -> offer row 2; free_en row 2 at H+1; clear_lines=8'b0000_0100 at H+3 (H+2 with macro); next offer row 5.
REQ-033 rr_ptr=7, request_vector=8'b1000_0001 -> row 7 offered; after handshake, same requests -> row 0 (wrap).
REQ-034 Offer row 3, issue_ready=0 two cycles then request_vector[3]=0 -> issue_valid low next cycle, no free_en, rr_ptr unchanged.
REQ-035 issue_lat=0 and issue_lat=15 (MAX_LAT=8) -> clear at H+1 and H+8 respectively; busy high H+1..H+7 for latter.
REQ-036 flush at H+2 with L=5 -> no clear_en ever; IDLE at H+3; rst low during BUSY -> all outputs zero immediately, no later pulses.

Source files
------------

// File: rtl/issue_select.sv
// issue_select: round-robin issue selector for a scheduler row array.
// Picks one ready row, offers it to a functional unit, and after the handshake
// releases the row (free_en) and broadcasts its dependency clear (clear_en)
// once the FU latency has elapsed.
// Optional build macro ISSUE_SELECT_EARLY_WAKEUP_EN: fire the dependency clear
// one cycle before completion so dependents can issue back-to-back.
module issue_select #(
  parameter int NUM_ROWS = 8,
  parameter int MAX_LAT  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_ROWS-1:0]          request_vector,
  input  logic [$clog2(MAX_LAT+1)-1:0] issue_lat,
  input  logic                         issue_ready,
  input  logic                         flush,
  output logic                         issue_valid,
  output logic [$clog2(NUM_ROWS)-1:0]  issue_row,
  output logic                         free_en,
  output logic [$clog2(NUM_ROWS)-1:0]  free_row_index,
  output logic                         clear_en,
  output logic [NUM_ROWS-1:0]          clear_lines,
  output logic                         busy
);

  localparam int RW = $clog2(NUM_ROWS);
  localparam int LW = $clog2(MAX_LAT+1);

`ifdef ISSUE_SELECT_EARLY_WAKEUP_EN
  // Clear one cycle ahead of completion, but never earlier than H+1.
  localparam logic [LW-1:0] HS_CLR_MAX = LW'(2);
  localparam logic [LW-1:0] BUSY_CLR_AT = LW'(3);
`else
  // Clear in the completion cycle itself.
  localparam logic [LW-1:0] HS_CLR_MAX = LW'(1);
  localparam logic [LW-1:0] BUSY_CLR_AT = LW'(2);
`endif

  typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       cnt_q, cnt_d;
  logic [RW-1:0]       rr_q, rr_d;
  logic                valid_d;
  logic [RW-1:0]       row_d;
  logic                free_en_d;
  logic [RW-1:0]       free_idx_d;
  logic                clear_en_d;
  logic [NUM_ROWS-1:0] clear_lines_d;
  logic [LW-1:0]       lat_eff;

  // Latency clamp: zero behaves as one cycle, anything above MAX_LAT saturates.
  function automatic logic [LW-1:0] sat_lat(input logic [LW-1:0] lat);
    if (lat == '0)
      return LW'(1);
    else if (lat > LW'(MAX_LAT))
      return LW'(MAX_LAT);
    else
      return lat;
  endfunction

  // First requesting row at or above ptr, wrapping around the array.
  function automatic logic [RW-1:0] pick_row(input logic [NUM_ROWS-1:0] req,
                                             input logic [RW-1:0] ptr);
    logic          found;
    logic [RW-1:0] idx;
    pick_row = ptr;
    found    = 1'b0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      idx = ptr + RW'(i);
      if (!found && req[idx]) begin
        pick_row = idx;
        found    = 1'b1;
      end
    end
  endfunction

  assign lat_eff = sat_lat(issue_lat);

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_d          = rr_q;
    valid_d       = issue_valid;
    row_d         = issue_row;
    free_en_d     = 1'b0;
    free_idx_d    = free_row_index;
    clear_en_d    = 1'b0;
    clear_lines_d = '0;

    case (state_q)
      IDLE: begin
        if (|request_vector) begin
          row_d   = pick_row(request_vector, rr_q);
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (!request_vector[issue_row]) begin
          // Requester withdrew: abandon the offer without touching rr_ptr.
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (issue_ready) begin
          valid_d    = 1'b0;
          free_en_d  = 1'b1;
          free_idx_d = issue_row;
          rr_d       = issue_row + RW'(1);
          if (lat_eff <= HS_CLR_MAX) begin
            clear_en_d    = 1'b1;
            clear_lines_d = NUM_ROWS'(1) << issue_row;
          end
          if (lat_eff == LW'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = lat_eff;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - LW'(1);
        if (cnt_q == BUSY_CLR_AT) begin
          clear_en_d    = 1'b1;
          clear_lines_d = NUM_ROWS'(1) << issue_row;
        end
        if (cnt_q <= LW'(2)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Flush kills everything except the release of a row handed over this cycle.
    if (flush) begin
      state_d       = IDLE;
      valid_d       = 1'b0;
      row_d         = issue_row;
      cnt_d         = '0;
      rr_d          = rr_q;
      clear_en_d    = 1'b0;
      clear_lines_d = '0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rr_q           <= '0;
      issue_valid    <= 1'b0;
      issue_row      <= '0;
      free_en        <= 1'b0;
      free_row_index <= '0;
      clear_en       <= 1'b0;
      clear_lines    <= '0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rr_q           <= rr_d;
      issue_valid    <= valid_d;
      issue_row      <= row_d;
      free_en        <= free_en_d;
      free_row_index <= free_idx_d;
      clear_en       <= clear_en_d;
      clear_lines    <= clear_lines_d;
      busy           <= (state_d == BUSY);
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// tb_issue_select: directed bench for issue_select (NUM_ROWS=8, MAX_LAT=8).
// Expected free/clear pulses are queued when a handshake is set up and are
// matched against the DUT pulses cycle by cycle.
module tb_issue_select;

  logic       clk;
  logic       rst;
  logic [7:0] request_vector;
  logic [3:0] issue_lat;
  logic       issue_ready;
  logic       flush;
  logic       issue_valid;
  logic [2:0] issue_row;
  logic       free_en;
  logic [2:0] free_row_index;
  logic       clear_en;
  logic [7:0] clear_lines;
  logic       busy;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } ev_t;

  ev_t free_q[$];
  ev_t clr_q[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  issue_select dut (
    .clk            (clk),
    .rst            (rst),
    .request_vector (request_vector),
    .issue_lat      (issue_lat),
    .issue_ready    (issue_ready),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_row      (issue_row),
    .free_en        (free_en),
    .free_row_index (free_row_index),
    .clear_en       (clear_en),
    .clear_lines    (clear_lines),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock, then match pulses against the scoreboard.
  task automatic step();
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (free_en) begin
      if (free_q.size() == 0) chk("free_en_unexpected", free_en, 1'b0);
      else begin
        e = free_q.pop_front();
        chk("free_cycle", cyc, e.cyc);
        chk("free_row", free_row_index, e.val);
      end
    end else if (free_q.size() > 0 && free_q[0].cyc <= cyc) begin
      e = free_q.pop_front();
      chk("free_en_due", free_en, 1'b1);
    end
    if (clear_en) begin
      if (clr_q.size() == 0) chk("clear_en_unexpected", clear_en, 1'b0);
      else begin
        e = clr_q.pop_front();
        chk("clear_cycle", cyc, e.cyc);
        chk("clear_lines", clear_lines, e.val);
      end
    end else begin
      chk("clear_lines_idle", clear_lines, 8'h00);
      if (clr_q.size() > 0 && clr_q[0].cyc <= cyc) begin
        e = clr_q.pop_front();
        chk("clear_en_due", clear_en, 1'b1);
      end
    end
  endtask

  // Step until an offer appears (bounded), then check the offered row.
  task automatic wait_offer(input logic [2:0] exp_row, input string tag);
    int n = 0;
    while (!issue_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, issue_valid, 1'b1);
    chk({tag, "_row"}, issue_row, exp_row);
  endtask

  // Current cycle is the handshake cycle H: queue release and clear.
  task automatic push_hs(input logic [2:0] row, input int lat);
    int l;
    int d;
    l = (lat == 0) ? 1 : ((lat > 8) ? 8 : lat);
`ifdef ISSUE_SELECT_EARLY_WAKEUP_EN
    d = (l > 1) ? l - 1 : 1;
`else
    d = l;
`endif
    free_q.push_back('{cyc + 1, {5'b0, row}});
    clr_q.push_back('{cyc + d, 8'h01 << row});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, issue_valid, 1'b0);
    chk({tag, "_row"}, issue_row, 3'd0);
    chk({tag, "_free_en"}, free_en, 1'b0);
    chk({tag, "_free_idx"}, free_row_index, 3'd0);
    chk({tag, "_clear_en"}, clear_en, 1'b0);
    chk({tag, "_clear_lines"}, clear_lines, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    request_vector = 8'h00;
    issue_lat = 4'd0;
    issue_ready = 1'b0;
    flush = 1'b0;
    #1;
    chk_all_zero("reset_async");
    step();
    step();
    chk_all_zero("reset_held");
    rst = 1'b1;
    step();
    chk_all_zero("post_reset_idle");

    // Basic issue: rows 2 and 5 requesting, latency 3.
    request_vector = 8'b0010_0100;
    issue_ready = 1'b1;
    issue_lat = 4'd3;
    wait_offer(3'd2, "offer_r2");
    push_hs(3'd2, 3);
    step();
    chk("h1_valid_low", issue_valid, 1'b0);
    chk("h1_busy", busy, 1'b1);
    step();
    chk("h2_busy", busy, 1'b1);
    step();
    chk("h3_busy_low", busy, 1'b0);
    wait_offer(3'd5, "offer_r5");
    push_hs(3'd5, 3);
    step();
    request_vector = 8'b1000_0001;
    issue_lat = 4'd1;

    // Round-robin wrap: pointer at 6, rows 7 and 0 requesting.
    wait_offer(3'd7, "offer_r7");
    push_hs(3'd7, 1);
    step();
    chk("lat1_no_busy", busy, 1'b0);
    wait_offer(3'd0, "offer_wrap_r0");
    push_hs(3'd0, 1);
    step();
    request_vector = 8'h02;
    issue_lat = 4'd0;

    // Zero latency behaves as one cycle.
    wait_offer(3'd1, "offer_lat0");
    push_hs(3'd1, 0);
    step();
    request_vector = 8'h10;
    issue_lat = 4'd15;

    // Latency above MAX_LAT saturates to 8.
    wait_offer(3'd4, "offer_lat15");
    push_hs(3'd4, 15);
    step();
    request_vector = 8'h00;
    chk("sat_busy_h1", busy, 1'b1);
    for (int k = 2; k <= 7; k++) begin
      step();
      chk("sat_busy_mid", busy, 1'b1);
    end
    step();
    chk("sat_busy_h8", busy, 1'b0);

    // Withdrawn request drops the offer with no release.
    issue_ready = 1'b0;
    request_vector = 8'h08;
    wait_offer(3'd3, "offer_drop");
    step();
    chk("drop_hold1_valid", issue_valid, 1'b1);
    chk("drop_hold1_row", issue_row, 3'd3);
    step();
    chk("drop_hold2_valid", issue_valid, 1'b1);
    chk("drop_hold2_row", issue_row, 3'd3);
    request_vector = 8'h00;
    step();
    chk("drop_valid_low", issue_valid, 1'b0);
    // Pointer still 5 after the drop, so rows {0,4} must pick 0.
    issue_ready = 1'b1;
    issue_lat = 4'd2;
    request_vector = 8'h11;
    wait_offer(3'd0, "offer_after_drop");
    push_hs(3'd0, 2);
    step();
    request_vector = 8'h02;
    issue_lat = 4'd5;

    // Flush two cycles after handshake cancels the pending clear.
    wait_offer(3'd1, "offer_flush");
    free_q.push_back('{cyc + 1, 8'h01});
    step();
    request_vector = 8'h00;
    step();
    chk("flush_pre_busy", busy, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy_low", busy, 1'b0);
    chk("flush_valid_low", issue_valid, 1'b0);
    repeat (8) step();

    // Reset during BUSY: immediate clear, no later pulses.
    request_vector = 8'h04;
    issue_lat = 4'd6;
    wait_offer(3'd2, "offer_rst");
    free_q.push_back('{cyc + 1, 8'h02});
    step();
    request_vector = 8'h00;
    step();
    chk("rst_pre_busy", busy, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_busy_async");
    step();
    step();
    rst = 1'b1;
    repeat (10) step();
    chk_all_zero("rst_quiet");
    request_vector = 8'h81;
    issue_lat = 4'd1;
    wait_offer(3'd0, "offer_post_rst");
    push_hs(3'd0, 1);
    step();
    request_vector = 8'h00;
    repeat (4) step();

    chk("scoreboard_drained", free_q.size() + clr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
